// File: rtl/bbox_pkg.sv
// Shared types and defaults for the binary bounding-box extractor.
package bbox_pkg;

   typedef enum logic [1:0] {
      WAIT_FRAME = 2'd0,
      ACTIVE     = 2'd1,
      REPORT     = 2'd2
   } bbox_state_e;

   localparam int unsigned BBOX_X_W = 11;
   localparam int unsigned BBOX_Y_W = 10;

   // Pixel value that means "background"; anything else is foreground.
   localparam logic [7:0] BBOX_BG = 8'h00;

endpackage

// File: rtl/binary_bbox_extract_video_pos_counter.sv
// Pixel position tracker: registers vsyn/en, derives frame/line strobes and
// saturating x/y coordinates of the pixel currently presented on en_i.
module video_pos_counter
   import bbox_pkg::*;
#(
   parameter int unsigned X_W = BBOX_X_W,
   parameter int unsigned Y_W = BBOX_Y_W
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           vsyn_i,
   input  logic           en_i,
   output logic [X_W-1:0] x_o,
   output logic [Y_W-1:0] y_o,
   output logic           frame_start_o,
   output logic           frame_end_o
);

   logic           vsyn_q;
   logic           en_q;
   logic [X_W-1:0] x_q, x_d;
   logic [Y_W-1:0] y_q, y_d;
   logic           line_end;

   assign frame_start_o = vsyn_q & ~vsyn_i;
   assign frame_end_o   = vsyn_i & ~vsyn_q;
   assign line_end      = en_q & ~en_i;

   // x_q is the column the next en-high cycle will occupy, so the current
   // pixel's coordinate is the register value itself.
   assign x_o = x_q;
   assign y_o = y_q;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (frame_start_o) begin
         x_d = '0;
         y_d = '0;
      end else if (line_end) begin
         x_d = '0;
         if (y_q != '1) y_d = y_q + Y_W'(1);
      end else if (en_i && (x_q != '1)) begin
         x_d = x_q + X_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vsyn_q <= 1'b0;
         en_q   <= 1'b0;
         x_q    <= '0;
         y_q    <= '0;
      end else begin
         vsyn_q <= vsyn_i;
         en_q   <= en_i;
         x_q    <= x_d;
         y_q    <= y_d;
      end
   end

endmodule

// File: rtl/binary_bbox_extract.sv
// Per-frame bounding box of foreground pixels in a binary video stream.
// Optional feature: define BBOX_PIXEL_COUNT_EN to add the o_pix_cnt output.
module binary_bbox_extract
   import bbox_pkg::*;
#(
   parameter int unsigned X_W = BBOX_X_W,
   parameter int unsigned Y_W = BBOX_Y_W
) (
   input  logic                 clk_i,
   input  logic                 a_rst_i,
   input  logic                 i_hsyn,
   input  logic                 i_vsyn,
   input  logic                 i_en,
   input  logic [7:0]           i_binary,
   output logic                 o_valid,
   output logic                 o_found,
   output logic [X_W-1:0]       o_x_min,
   output logic [X_W-1:0]       o_x_max,
   output logic [Y_W-1:0]       o_y_min,
   output logic [Y_W-1:0]       o_y_max
`ifdef BBOX_PIXEL_COUNT_EN
   ,
   output logic [X_W+Y_W-1:0]   o_pix_cnt
`endif
);

   logic [X_W-1:0] pos_x;
   logic [Y_W-1:0] pos_y;
   logic           frame_start;
   logic           frame_end;

   // Line sync carries no information needed here; coordinates come from en.
   logic unused_hsyn;
   assign unused_hsyn = i_hsyn;

   video_pos_counter #(
      .X_W (X_W),
      .Y_W (Y_W)
   ) u_pos (
      .clk_i         (clk_i),
      .rst_i         (a_rst_i),
      .vsyn_i        (i_vsyn),
      .en_i          (i_en),
      .x_o           (pos_x),
      .y_o           (pos_y),
      .frame_start_o (frame_start),
      .frame_end_o   (frame_end)
   );

   bbox_state_e state_q, state_d;
   logic        pix_hit;
   logic        load_out;
   logic        clr_acc;

   always_comb begin
      state_d  = state_q;
      pix_hit  = 1'b0;
      load_out = 1'b0;
      clr_acc  = 1'b0;
      case (state_q)
         WAIT_FRAME: begin
            if (frame_start) state_d = ACTIVE;
         end
         ACTIVE: begin
            if (frame_end) begin
               state_d  = REPORT;
               load_out = 1'b1;
            end else begin
               pix_hit = i_en && !i_vsyn && (i_binary != BBOX_BG);
            end
         end
         REPORT: begin
            // A 1-cycle vsyn pulse puts the next frame start in this cycle.
            clr_acc = 1'b1;
            state_d = frame_start ? ACTIVE : WAIT_FRAME;
         end
         default: state_d = WAIT_FRAME;
      endcase
   end

   logic           found_q, found_d;
   logic [X_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
   logic [Y_W-1:0] ymin_q, ymin_d, ymax_q, ymax_d;

   always_comb begin
      found_d = found_q;
      xmin_d  = xmin_q;
      xmax_d  = xmax_q;
      ymin_d  = ymin_q;
      ymax_d  = ymax_q;
      if (clr_acc) begin
         found_d = 1'b0;
         xmin_d  = '0;
         xmax_d  = '0;
         ymin_d  = '0;
         ymax_d  = '0;
      end else if (pix_hit) begin
         found_d = 1'b1;
         if (!found_q) begin
            xmin_d = pos_x;
            xmax_d = pos_x;
            ymin_d = pos_y;
            ymax_d = pos_y;
         end else begin
            if (pos_x < xmin_q) xmin_d = pos_x;
            if (pos_x > xmax_q) xmax_d = pos_x;
            if (pos_y < ymin_q) ymin_d = pos_y;
            if (pos_y > ymax_q) ymax_d = pos_y;
         end
      end
   end

   logic           valid_q;
   logic           found_out_q;
   logic [X_W-1:0] xmin_out_q, xmax_out_q;
   logic [Y_W-1:0] ymin_out_q, ymax_out_q;

   always_ff @(posedge clk_i or posedge a_rst_i) begin
      if (a_rst_i) begin
         state_q     <= WAIT_FRAME;
         found_q     <= 1'b0;
         xmin_q      <= '0;
         xmax_q      <= '0;
         ymin_q      <= '0;
         ymax_q      <= '0;
         valid_q     <= 1'b0;
         found_out_q <= 1'b0;
         xmin_out_q  <= '0;
         xmax_out_q  <= '0;
         ymin_out_q  <= '0;
         ymax_out_q  <= '0;
      end else begin
         state_q <= state_d;
         found_q <= found_d;
         xmin_q  <= xmin_d;
         xmax_q  <= xmax_d;
         ymin_q  <= ymin_d;
         ymax_q  <= ymax_d;
         valid_q <= load_out;
         if (load_out) begin
            found_out_q <= found_q;
            xmin_out_q  <= xmin_q;
            xmax_out_q  <= xmax_q;
            ymin_out_q  <= ymin_q;
            ymax_out_q  <= ymax_q;
         end
      end
   end

   assign o_valid = valid_q;
   assign o_found = found_out_q;
   assign o_x_min = xmin_out_q;
   assign o_x_max = xmax_out_q;
   assign o_y_min = ymin_out_q;
   assign o_y_max = ymax_out_q;

`ifdef BBOX_PIXEL_COUNT_EN
   localparam int unsigned CNT_W = X_W + Y_W;

   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_out_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_acc) cnt_d = '0;
      else if (pix_hit && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i or posedge a_rst_i) begin
      if (a_rst_i) begin
         cnt_q     <= '0;
         cnt_out_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (load_out) cnt_out_q <= cnt_q;
      end
   end

   assign o_pix_cnt = cnt_out_q;
`endif

endmodule

// File: tb/tb_binary_bbox_extract.sv
// Directed self-checking bench for binary_bbox_extract (checks o_pix_cnt
// too when BBOX_PIXEL_COUNT_EN is defined).
`timescale 1ns/1ps
module tb_binary_bbox_extract;

   localparam int unsigned X_W   = 11;
   localparam int unsigned Y_W   = 10;
   localparam int unsigned BOX_W = 1 + 2*X_W + 2*Y_W;

   logic                 clk_i = 1'b0;
   logic                 a_rst_i;
   logic                 i_hsyn;
   logic                 i_vsyn;
   logic                 i_en;
   logic [7:0]           i_binary;
   logic                 o_valid;
   logic                 o_found;
   logic [X_W-1:0]       o_x_min, o_x_max;
   logic [Y_W-1:0]       o_y_min, o_y_max;
`ifdef BBOX_PIXEL_COUNT_EN
   logic [X_W+Y_W-1:0]   o_pix_cnt;
`endif

   binary_bbox_extract #(
      .X_W (X_W),
      .Y_W (Y_W)
   ) dut (
      .clk_i    (clk_i),
      .a_rst_i  (a_rst_i),
      .i_hsyn   (i_hsyn),
      .i_vsyn   (i_vsyn),
      .i_en     (i_en),
      .i_binary (i_binary),
      .o_valid  (o_valid),
      .o_found  (o_found),
      .o_x_min  (o_x_min),
      .o_x_max  (o_x_max),
      .o_y_min  (o_y_min),
      .o_y_max  (o_y_max)
`ifdef BBOX_PIXEL_COUNT_EN
      ,
      .o_pix_cnt (o_pix_cnt)
`endif
   );

   always #5 clk_i = ~clk_i;

   int unsigned cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int unsigned        cyc;
      logic [BOX_W-1:0]   box;
      logic [X_W+Y_W-1:0] cnt;
   } rep_t;

   rep_t reps[$];
   rep_t mon_r;

   // Every negedge with o_valid high is recorded as one report.
   always @(negedge clk_i) begin
      if (o_valid === 1'b1) begin
         mon_r.cyc = cyc;
         mon_r.box = {o_found, o_x_min, o_x_max, o_y_min, o_y_max};
`ifdef BBOX_PIXEL_COUNT_EN
         mon_r.cnt = o_pix_cnt;
`else
         mon_r.cnt = '0;
`endif
         reps.push_back(mon_r);
      end
   end

   int fg_x[$];
   int fg_y[$];
   int unsigned rise_cyc;

   function automatic logic [BOX_W-1:0] box(input logic f, input int x0, input int x1,
                                             input int y0, input int y1);
      return {f, X_W'(x0), X_W'(x1), Y_W'(y0), Y_W'(y1)};
   endfunction

   function automatic bit is_fg(input int x, input int y);
      foreach (fg_x[i]) if (fg_x[i] == x && fg_y[i] == y) return 1'b1;
      return 1'b0;
   endfunction

   task automatic fg_set(input int n, input int x0, input int y0, input int x1, input int y1);
      fg_x.delete();
      fg_y.delete();
      if (n > 0) begin fg_x.push_back(x0); fg_y.push_back(y0); end
      if (n > 1) begin fg_x.push_back(x1); fg_y.push_back(y1); end
   endtask

   task automatic drive(input logic v, input logic e, input logic [7:0] b);
      @(negedge clk_i);
      i_vsyn   = v;
      i_en     = e;
      i_binary = b;
      i_hsyn   = ~e & ~v;
   endtask

   task automatic send_line(input int w, input int y);
      for (int x = 0; x < w; x++) drive(1'b0, 1'b1, is_fg(x, y) ? 8'hFF : 8'h00);
      drive(1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b0, 8'h00);
   endtask

   // Assumes vsyn is high on entry; first cycle is the vsyn falling edge.
   task automatic send_frame(input int w, input int h, input int vhigh, input bit vpix);
      drive(1'b0, 1'b0, 8'h00);
      for (int y = 0; y < h; y++) send_line(w, y);
      drive(1'b1, vpix, vpix ? 8'h80 : 8'h00);
      rise_cyc = cyc;
      for (int i = 1; i < vhigh; i++) drive(1'b1, vpix, vpix ? 8'h01 : 8'h00);
   endtask

   task automatic test_reset();
      a_rst_i  = 1'b1;
      i_vsyn   = 1'b0;
      i_en     = 1'b0;
      i_hsyn   = 1'b0;
      i_binary = 8'h00;
      repeat (3) @(negedge clk_i);
      checks++;
      if (o_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: got %b expected 0", o_valid);
      end
      checks++;
      if ({o_found, o_x_min, o_x_max, o_y_min, o_y_max} !== '0) begin
         errors++;
         $display("FAIL reset_box: got %h expected 0", {o_found, o_x_min, o_x_max, o_y_min, o_y_max});
      end
      a_rst_i = 1'b0;
   endtask

   task automatic test_partial_discard();
      fg_set(2, 1, 1, 6, 0);
      for (int y = 0; y < 2; y++) send_line(8, y);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'h00);
      checks++;
      if (reps.size() != 0) begin
         errors++;
         $display("FAIL partial_no_report: got %0d reports expected 0", reps.size());
      end
   endtask

   task automatic check_report(input string name, input int unsigned b,
                               input logic [BOX_W-1:0] exp_box, input int exp_cnt);
      rep_t r;
      checks++;
      if (reps.size() != b + 1) begin
         errors++;
         $display("FAIL %s_count: got %0d reports expected %0d", name, reps.size(), b + 1);
      end else begin
         r = reps[b];
         checks++;
         if (r.box !== exp_box) begin
            errors++;
            $display("FAIL %s_box: got %h expected %h", name, r.box, exp_box);
         end
         checks++;
         if (r.cyc !== rise_cyc + 1) begin
            errors++;
            $display("FAIL %s_latency: got cycle %0d expected %0d", name, r.cyc, rise_cyc + 1);
         end
`ifdef BBOX_PIXEL_COUNT_EN
         checks++;
         if (r.cnt !== (X_W+Y_W)'(exp_cnt)) begin
            errors++;
            $display("FAIL %s_pixcnt: got %0d expected %0d", name, r.cnt, exp_cnt);
         end
`else
         if (exp_cnt < 0) $display("note: negative pixel count requested for %s", name);
`endif
      end
   endtask

   task automatic test_basic_box();
      int unsigned b;
      b = reps.size();
      fg_set(2, 2, 1, 5, 4);
      send_frame(8, 6, 4, 1'b0);
      repeat (2) @(negedge clk_i);
      check_report("basic", b, box(1'b1, 2, 5, 1, 4), 2);
      checks++;
      if ({o_valid, o_found, o_x_min, o_x_max, o_y_min, o_y_max} !== {1'b0, box(1'b1, 2, 5, 1, 4)}) begin
         errors++;
         $display("FAIL basic_hold: got %h expected %h",
                  {o_valid, o_found, o_x_min, o_x_max, o_y_min, o_y_max}, {1'b0, box(1'b1, 2, 5, 1, 4)});
      end
   endtask

   task automatic test_empty_frame();
      int unsigned b;
      b = reps.size();
      fg_set(0, 0, 0, 0, 0);
      send_frame(8, 6, 3, 1'b0);
      repeat (2) @(negedge clk_i);
      check_report("empty", b, box(1'b0, 0, 0, 0, 0), 0);
   endtask

   task automatic test_single_corner();
      int unsigned b;
      b = reps.size();
      fg_set(1, 7, 5, 0, 0);
      send_frame(8, 6, 3, 1'b0);
      repeat (2) @(negedge clk_i);
      check_report("corner", b, box(1'b1, 7, 7, 5, 5), 1);
   endtask

   task automatic test_vsyn_rise_pixel();
      int unsigned b;
      b = reps.size();
      fg_set(1, 3, 3, 0, 0);
      send_frame(8, 6, 3, 1'b1);
      repeat (2) @(negedge clk_i);
      check_report("vrise", b, box(1'b1, 3, 3, 3, 3), 1);
   endtask

   task automatic test_back_to_back();
      int unsigned b;
      int unsigned rise_a;
      rep_t        r;
      b = reps.size();
      fg_set(1, 1, 0, 0, 0);
      send_frame(8, 6, 1, 1'b0);
      rise_a = rise_cyc;
      fg_set(1, 6, 5, 0, 0);
      send_frame(8, 6, 3, 1'b0);
      repeat (2) @(negedge clk_i);
      checks++;
      if (reps.size() != b + 2) begin
         errors++;
         $display("FAIL b2b_count: got %0d reports expected %0d", reps.size(), b + 2);
      end else begin
         r = reps[b];
         checks++;
         if (r.box !== box(1'b1, 1, 1, 0, 0) || r.cyc !== rise_a + 1) begin
            errors++;
            $display("FAIL b2b_first: got %h at %0d expected %h at %0d",
                     r.box, r.cyc, box(1'b1, 1, 1, 0, 0), rise_a + 1);
         end
         r = reps[b + 1];
         checks++;
         if (r.box !== box(1'b1, 6, 6, 5, 5) || r.cyc !== rise_cyc + 1) begin
            errors++;
            $display("FAIL b2b_second: got %h at %0d expected %h at %0d",
                     r.box, r.cyc, box(1'b1, 6, 6, 5, 5), rise_cyc + 1);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int unsigned b;
      b = reps.size();
      fg_set(1, 4, 2, 0, 0);
      drive(1'b0, 1'b0, 8'h00);
      for (int y = 0; y < 3; y++) send_line(8, y);
      @(negedge clk_i);
      #2 a_rst_i = 1'b1;
      #1;
      checks++;
      if ({o_valid, o_found, o_x_min, o_x_max, o_y_min, o_y_max} !== '0) begin
         errors++;
         $display("FAIL rstmid_async_clear: got %h expected 0",
                  {o_valid, o_found, o_x_min, o_x_max, o_y_min, o_y_max});
      end
      @(negedge clk_i);
      a_rst_i = 1'b0;
      for (int y = 3; y < 6; y++) send_line(8, y);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h00);
      repeat (2) @(negedge clk_i);
      checks++;
      if (reps.size() != b || {o_found, o_x_min, o_x_max, o_y_min, o_y_max} !== '0) begin
         errors++;
         $display("FAIL rstmid_no_report: got %0d reports box %h expected %0d reports box 0",
                  reps.size(), {o_found, o_x_min, o_x_max, o_y_min, o_y_max}, b);
      end
      fg_set(2, 0, 0, 7, 5);
      send_frame(8, 6, 3, 1'b0);
      repeat (2) @(negedge clk_i);
      check_report("rstmid_next", b, box(1'b1, 0, 7, 0, 5), 2);
   endtask

   task automatic test_x_saturation();
      int unsigned b;
      b = reps.size();
      fg_set(2, 10, 0, 2050, 0);
      send_frame(2100, 1, 3, 1'b0);
      repeat (2) @(negedge clk_i);
      check_report("xsat", b, box(1'b1, 10, 2047, 0, 0), 2);
   endtask

   initial begin
      test_reset();
      test_partial_discard();
      test_basic_box();
      test_empty_frame();
      test_single_corner();
      test_vsyn_rise_pixel();
      test_back_to_back();
      test_reset_mid_frame();
      test_x_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/binary_bbox_extract.md
# binary_bbox_extract

Consumer of the morphologically filtered binary video stream: it counts pixel coordinates from the hsyn/vsyn/en timing and tracks the bounding box of foreground pixels each frame. At each frame end it reports the box, which the eye-tracking logic uses as the pupil region. It sits directly downstream of the open-filtering stage and reads that stage's output stream unchanged.

## Interface
- X_W, 11: column counter / x output width
- Y_W, 10: row counter / y output width
- clk_i  input  1  pixel clock
- a_rst_i  input  1  reset, asynchronous, active-high
- i_hsyn  input  1  line sync (pass-through information only, not used for counting)
- i_vsyn  input  1  frame sync, active-high during vertical blanking
- i_en  input  1  pixel valid
- i_binary  input  8  binary pixel; foreground when != 8'h00
- o_valid  output  1  one-cycle pulse, results valid
- o_found  output  1  at least one foreground pixel in frame
- o_x_min / o_x_max  output  X_W  column bounds, inclusive
- o_y_min / o_y_max  output  Y_W  row bounds, inclusive

## Operation
- Coordinates: x = index of i_en-high cycle within line (first = 0); y = index of line within frame (first = 0). A line ends at an i_en falling edge: x clears, y increments. At the vsyn falling edge, x and y both clear.
- Counters saturate at all-ones and never wrap. A pixel at a saturated coordinate is still tracked at the saturated value.
- FSM states:
  - WAIT_FRAME: reset state; ignores pixels; goes to ACTIVE on the i_vsyn falling edge (i_vsyn low, registered copy high).
  - ACTIVE: each i_en & foreground pixel updates min/max. The first foreground pixel loads all four bounds and sets found. On the i_vsyn rising edge, goes to REPORT.
  - REPORT: one cycle; outputs loaded, o_valid = 1; accumulators and found clear; goes to WAIT_FRAME.
- After reset, the first partial frame is discarded. The first report follows the first complete frame.
- A pixel with i_en high in the same cycle as the vsyn rising edge is ignored.
- A pixel with i_en high while i_vsyn is high is ignored.
- Empty frame: o_found = 0 and all bound outputs = 0.
- Outputs hold their values between reports.

## Timing
- Reset: all outputs 0, FSM = WAIT_FRAME, counters and accumulators 0, registered vsyn/en = 0.
- o_valid rises in the cycle after the clock edge that samples the i_vsyn rise. Latency is 1 cycle.
- o_valid is high for exactly one cycle per completed frame.
- Bound outputs change only in the o_valid cycle.
- Reset asserted mid-frame clears everything asynchronously. No report is issued for that frame.
- Minimum vsyn low time is 1 cycle. Back-to-back frames with a 1-cycle vsyn high still produce one report each.

## Configuration
- BBOX_PIXEL_COUNT_EN:
  - Defined: adds output o_pix_cnt (X_W+Y_W bits), the count of foreground pixels in the frame. It saturates, updates in the o_valid cycle, and resets to 0.
  - Undefined: no counter and no port.

## Structure
- Package bbox_pkg holds:
  - the FSM state enum (WAIT_FRAME, ACTIVE, REPORT);
  - default width constants;
  - the foreground test constant 8'h00.
- One sub-module, video_pos_counter, handles edge detection of i_en/i_vsyn and the saturating x/y counters. It outputs x, y, frame_start and frame_end strobes.

## Test plan
- 8x6 frame with foreground at (2,1) and (5,4) only -> after the first discarded frame, o_valid pulse with x 2..5, y 1..4, o_found 1 (o_pix_cnt 2 with BBOX_PIXEL_COUNT_EN).
- 8x6 all-zero frame -> o_valid pulse with o_found 0 and all bounds 0.
- Single foreground pixel at (7,5) -> x_min = x_max = 7, y_min = y_max = 5.
- Foreground pixel with i_en high in the vsyn rising cycle, plus one at (3,3) -> bounds exactly (3,3); o_valid 1 cycle after the vsyn rise.
- a_rst_i pulsed mid-frame 2 -> no report for frame 2; outputs stay 0; the next complete frame reports correctly.
- 2100-pixel-wide line with foreground at column 2050, X_W = 11 -> o_x_max = 2047 (saturated).
